// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter
// Purpose: FSM state enum, data-length encodings, line levels and small
//          helpers used by uart_tx.
// Ports:   none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Keeps only the bits that are actually sent, so parity over the whole
  // shadow word equals parity over the transmitted bits.
  function automatic logic [7:0] len_mask(input logic [1:0] len);
    logic [7:0] m;
    case (len)
      LEN_5:   m = 8'h1F;
      LEN_6:   m = 8'h3F;
      LEN_7:   m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Index of the final data bit: 4 for 5-bit words up to 7 for 8-bit words.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] len);
    return {1'b0, len} + 3'd4;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period down-counter with one-cycle bit-end pulse
// Purpose: counts CLKS_PER_BIT-1 down to 0; tick_o is high on the last cycle
//          of every bit period. restart_i reloads the count so the first
//          bit after leaving IDLE gets a full period.
// Ports:   clk       - system clock
//          rst       - synchronous active-high reset
//          restart_i - reload counter to CLKS_PER_BIT-1
//          tick_o    - high during the final cycle of a bit period
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == 16'd0);

  always_comb begin
    cnt_d = cnt_q - 16'd1;
    if (restart_i || tick_o) begin
      cnt_d = RELOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - asynchronous serial transmitter, 5-8 data bits, LSB first
// Purpose: latches a word and its frame format in IDLE, then sends start,
//          data, optional parity and 1 or 2 stop bits on a registered line.
//          Optional parity hardware is built only when UART_TX_PARITY_EN is
//          defined; otherwise parity_en/even_odd_parity are ignored.
// Ports:   clk              - system clock
//          rst              - synchronous active-high reset
//          tx_start         - frame request, sampled only in IDLE
//          data_in          - data word, bits above the length ignored
//          parity_en        - append parity bit (parity build only)
//          even_odd_parity  - 0 even, 1 odd (parity build only)
//          data_bit_len     - 00=5 .. 11=8 data bits
//          num_of_stop_bits - 0 one stop bit, 1 two stop bits
//          sout             - serial output, idle high
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  input  logic       parity_en,
  input  logic       even_odd_parity,
  input  logic [1:0] data_bit_len,
  input  logic       num_of_stop_bits,
  output logic       sout
);

  import uart_pkg::*;

  uart_tx_state_e state_q, state_d;
  logic [7:0]     data_q, data_d;
  logic [1:0]     len_q, len_d;
  logic           nstop_q, nstop_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic           stop_idx_q, stop_idx_d;
  logic           sout_q, sout_d;
  logic           restart;
  logic           tick;
  logic [2:0]     next_idx;

`ifdef UART_TX_PARITY_EN
  logic pe_q, pe_d;
  logic odd_q, odd_d;
  logic parity_bit;

  // data_q is already masked to the selected length.
  assign parity_bit = (^data_q) ^ odd_q;
`else
  logic unused_parity;
  assign unused_parity = parity_en ^ even_odd_parity;
`endif

  assign next_idx = bit_idx_q + 3'd1;
  assign sout     = sout_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart_i(restart),
    .tick_o   (tick)
  );

  // sout_d is the level of the bit that starts on the next clock, which keeps
  // the line registered without adding a cycle of latency.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    len_d      = len_q;
    nstop_d    = nstop_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    sout_d     = sout_q;
    restart    = 1'b0;
`ifdef UART_TX_PARITY_EN
    pe_d       = pe_q;
    odd_d      = odd_q;
`endif
    case (state_q)
      IDLE: begin
        sout_d = IDLE_LEVEL;
        if (tx_start) begin
          state_d    = START;
          sout_d     = START_LEVEL;
          restart    = 1'b1;
          data_d     = data_in & len_mask(data_bit_len);
          len_d      = data_bit_len;
          nstop_d    = num_of_stop_bits;
          bit_idx_d  = 3'd0;
          stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          pe_d       = parity_en;
          odd_d      = even_odd_parity;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          sout_d    = data_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == last_bit_idx(len_q)) begin
            state_d    = STOP;
            sout_d     = IDLE_LEVEL;
            stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            if (pe_q) begin
              state_d = PARITY;
              sout_d  = parity_bit;
            end
`endif
          end else begin
            bit_idx_d = next_idx;
            sout_d    = data_q[next_idx];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d    = STOP;
          sout_d     = IDLE_LEVEL;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        sout_d = IDLE_LEVEL;
        if (tick) begin
          if (stop_idx_q == nstop_q) begin
            state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sout_d  = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= 8'd0;
      len_q      <= 2'd0;
      nstop_q    <= 1'b0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      sout_q     <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      pe_q       <= 1'b0;
      odd_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      len_q      <= len_d;
      nstop_q    <= nstop_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      sout_q     <= sout_d;
`ifdef UART_TX_PARITY_EN
      pe_q       <= pe_d;
      odd_q      <= odd_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
// Purpose: drives two transmitters (CLKS_PER_BIT=1 and 4) sharing the data
//          and format inputs, and checks sout every clock against expected
//          frames. Parity cases are exercised when UART_TX_PARITY_EN is set.
// Ports:   none (top-level bench).
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst1, rst4;
  logic       tx_start1, tx_start4;
  logic [7:0] data_in;
  logic       parity_en, even_odd_parity;
  logic [1:0] data_bit_len;
  logic       num_of_stop_bits;
  logic       sout1, sout4;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk             (clk),
    .rst             (rst1),
    .tx_start        (tx_start1),
    .data_in         (data_in),
    .parity_en       (parity_en),
    .even_odd_parity (even_odd_parity),
    .data_bit_len    (data_bit_len),
    .num_of_stop_bits(num_of_stop_bits),
    .sout            (sout1)
  );

  uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk             (clk),
    .rst             (rst4),
    .tx_start        (tx_start4),
    .data_in         (data_in),
    .parity_en       (parity_en),
    .even_odd_parity (even_odd_parity),
    .data_bit_len    (data_bit_len),
    .num_of_stop_bits(num_of_stop_bits),
    .sout            (sout4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sout_of(input int dut);
    return (dut == 1) ? sout1 : sout4;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Sends nframes frames with tx_start held high (back-to-back when >1),
  // checking every cycle including the single idle gap between frames.
  // mutate_at >= 0 overwrites data_in with 0xAA at that cycle of frame 0.
  task automatic run_frames(input string name, input int dut, input logic [7:0] d,
                            input logic [1:0] len, input logic pe, input logic eo,
                            input logic ns, input int nframes, input int mutate_at);
    logic exp_bits [0:11];
    int   nb;
    int   cpb;
    int   n;
    int   cyc;
    logic par;
    cpb = (dut == 1) ? 1 : 4;
    n   = int'(len) + 5;
    par = 1'b0;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_bits[1 + i] = d[i];
      par = par ^ d[i];
    end
    nb = 1 + n;
`ifdef UART_TX_PARITY_EN
    if (pe) begin
      exp_bits[nb] = par ^ eo;
      nb++;
    end
`endif
    exp_bits[nb] = 1'b1;
    nb++;
    if (ns) begin
      exp_bits[nb] = 1'b1;
      nb++;
    end
    data_in          = d;
    parity_en        = pe;
    even_odd_parity  = eo;
    data_bit_len     = len;
    num_of_stop_bits = ns;
    if (dut == 1) tx_start1 = 1'b1;
    else          tx_start4 = 1'b1;
    step();
    for (int f = 0; f < nframes; f++) begin
      if (f == nframes - 1) begin
        tx_start1 = 1'b0;
        tx_start4 = 1'b0;
      end
      cyc = 0;
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < cpb; k++) begin
          if (f == 0 && cyc == mutate_at) data_in = 8'hAA;
          check($sformatf("%s_f%0d_b%0d_c%0d", name, f, b, k), sout_of(dut), exp_bits[b]);
          cyc++;
          step();
        end
      end
      if (f < nframes - 1) begin
        check($sformatf("%s_gap%0d", name, f), sout_of(dut), 1'b1);
        step();
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_idle%0d", name, i), sout_of(dut), 1'b1);
      step();
    end
  endtask

  initial begin
    logic [0:9] golden;

    rst1             = 1'b1;
    rst4             = 1'b1;
    tx_start1        = 1'b1;
    tx_start4        = 1'b1;
    data_in          = 8'h00;
    parity_en        = 1'b0;
    even_odd_parity  = 1'b0;
    data_bit_len     = 2'b11;
    num_of_stop_bits = 1'b0;

    // Reset dominates tx_start.
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_sout1", sout1, 1'b1);
      check("reset_sout4", sout4, 1'b1);
    end
    tx_start1 = 1'b0;
    tx_start4 = 1'b0;
    rst1      = 1'b0;
    rst4      = 1'b0;
    step();
    check("post_reset_sout1", sout1, 1'b1);
    check("post_reset_sout4", sout4, 1'b1);

    // Hand-written frame: 0x05, 8N1, one-cycle bits.
    golden    = 10'b0101000001;
    data_in   = 8'h05;
    tx_start1 = 1'b1;
    step();
    tx_start1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("golden_b%0d", i), sout1, golden[i]);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("golden_idle%0d", i), sout1, 1'b1);
      step();
    end

    // Parity request: frame grows to 11 bits only in the parity build.
    run_frames("par_even_05", 1, 8'h05, 2'b11, 1'b1, 1'b0, 1'b0, 1, -1);
    run_frames("par_odd_05",  1, 8'h05, 2'b11, 1'b1, 1'b1, 1'b0, 1, -1);
    run_frames("par_len5_e1", 1, 8'hE1, 2'b00, 1'b1, 1'b0, 1'b1, 1, -1);

    // Data length boundaries; upper bits must not leak onto the line.
    run_frames("len5_ff_2s", 1, 8'hFF, 2'b00, 1'b0, 1'b0, 1'b1, 1, -1);
    run_frames("len5_e0_2s", 1, 8'hE0, 2'b00, 1'b0, 1'b0, 1'b1, 1, -1);
    run_frames("len6_c1",    4, 8'hC1, 2'b01, 1'b0, 1'b0, 1'b0, 1, -1);
    run_frames("len7_2a_2s", 4, 8'h2A, 2'b10, 1'b0, 1'b0, 1'b1, 1, -1);

    // Back-to-back frames with tx_start held high.
    run_frames("b2b_8n1_c4", 4, 8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 2, -1);
    run_frames("b2b_5n2_c1", 1, 8'h13, 2'b00, 1'b0, 1'b0, 1'b1, 3, -1);

    // Input change mid-frame is ignored.
    run_frames("mutate_05", 4, 8'h05, 2'b11, 1'b0, 1'b0, 1'b0, 1, 10);

    // Reset during DATA aborts the frame.
    data_in          = 8'h05;
    data_bit_len     = 2'b11;
    parity_en        = 1'b0;
    num_of_stop_bits = 1'b0;
    tx_start1        = 1'b1;
    step();
    tx_start1 = 1'b0;
    check("abort_start", sout1, 1'b0);
    step();
    check("abort_bit0", sout1, 1'b1);
    rst1 = 1'b1;
    step();
    check("abort_rst", sout1, 1'b1);
    rst1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("abort_idle%0d", i), sout1, 1'b1);
    end
    step();
    run_frames("after_abort", 1, 8'h05, 2'b11, 1'b0, 1'b0, 1'b0, 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
